// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target predictor with 2-bit saturating direction
// counters, a combinational lookup port and a single-entry update port.
// Optional feature: define BTP_FLUSH_EN to add a `flush` input that clears
// every valid bit and the occupancy count.
module branch_target_predictor #(
  parameter int unsigned ENTRIES   = 16,
  parameter logic [1:0]  CTR_RESET = 2'b01
) (
  input  logic                      clk,
  input  logic                      reset,
`ifdef BTP_FLUSH_EN
  input  logic                      flush,
`endif
  input  logic [31:0]               lookup_pc,
  output logic                      lookup_hit,
  output logic                      predict_taken,
  output logic [31:0]               predicted_pc,
  input  logic                      upd_valid,
  input  logic [31:0]               upd_pc,
  input  logic                      upd_taken,
  input  logic [31:0]               upd_target,
  output logic [$clog2(ENTRIES):0]  occupancy
);

  localparam int unsigned IDX = $clog2(ENTRIES);
  localparam int unsigned TW  = 30 - IDX;

  logic          validQ  [ENTRIES];
  logic [TW-1:0] tagQ    [ENTRIES];
  logic [31:0]   targetQ [ENTRIES];
  logic [1:0]    ctrQ    [ENTRIES];

  logic [IDX-1:0] lookupIdx;
  logic [TW-1:0]  lookupTag;
  logic [IDX-1:0] updIdx;
  logic [TW-1:0]  updTag;
  logic           updHit;

  // Byte-offset bits of both PCs never participate in indexing or tagging.
  logic unusedPcLowBits;
  assign unusedPcLowBits = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lookupIdx = lookup_pc[IDX+1:2];
  assign lookupTag = lookup_pc[31:IDX+2];
  assign updIdx    = upd_pc[IDX+1:2];
  assign updTag    = upd_pc[31:IDX+2];
  assign updHit    = validQ[updIdx] && (tagQ[updIdx] == updTag);

  // Zero-latency lookup from registered state only (no update bypass).
  always_comb begin
    lookup_hit    = validQ[lookupIdx] && (tagQ[lookupIdx] == lookupTag);
    predict_taken = lookup_hit && ctrQ[lookupIdx][1];
    predicted_pc  = lookup_hit ? targetQ[lookupIdx] : lookup_pc + 32'd4;
  end

  // Table state: reset, then flush (if built), then the single update entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        validQ[i]  <= 1'b0;
        tagQ[i]    <= '0;
        targetQ[i] <= '0;
        ctrQ[i]    <= CTR_RESET;
      end
      occupancy <= '0;
    end
`ifdef BTP_FLUSH_EN
    else if (flush) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        validQ[i] <= 1'b0;
      end
      occupancy <= '0;
    end
`endif
    else if (upd_valid) begin
      if (updHit) begin
        if (upd_taken) begin
          targetQ[updIdx] <= upd_target;
          if (ctrQ[updIdx] != 2'b11) ctrQ[updIdx] <= ctrQ[updIdx] + 2'd1;
        end else begin
          if (ctrQ[updIdx] != 2'b00) ctrQ[updIdx] <= ctrQ[updIdx] - 2'd1;
        end
      end else if (upd_taken) begin
        // Replacing an aliased valid entry leaves the count unchanged.
        if (!validQ[updIdx]) occupancy <= occupancy + 1'b1;
        validQ[updIdx]  <= 1'b1;
        tagQ[updIdx]    <= updTag;
        targetQ[updIdx] <= upd_target;
        ctrQ[updIdx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor (ENTRIES=16): directed
// vector table, hand-written multi-cycle sequences, and a randomized phase
// compared against a behavioural table model.
module tb_branch_target_predictor;

  localparam int unsigned N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
`ifdef BTP_FLUSH_EN
  logic        flush = 1'b0;
`endif
  logic [31:0] lookup_pc = '0;
  logic        lookup_hit;
  logic        predict_taken;
  logic [31:0] predicted_pc;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic [4:0]  occupancy;

  int unsigned nChecks = 0;
  int unsigned nFails  = 0;

  branch_target_predictor #(.ENTRIES(16), .CTR_RESET(2'b01)) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef BTP_FLUSH_EN
    .flush        (flush),
`endif
    .lookup_pc    (lookup_pc),
    .lookup_hit   (lookup_hit),
    .predict_taken(predict_taken),
    .predicted_pc (predicted_pc),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: per-slot records keyed by (pc/4) mod 16, tag = pc/64.
  bit          mValid  [N];
  int unsigned mTag    [N];
  int unsigned mTarget [N];
  int          mCtr    [N];

  function automatic int unsigned slotOf(input logic [31:0] pc);
    return (pc >> 2) % N;
  endfunction

  function automatic int unsigned modelOcc();
    int unsigned c = 0;
    for (int i = 0; i < N; i++) if (mValid[i]) c++;
    return c;
  endfunction

  task automatic modelClear();
    for (int i = 0; i < N; i++) begin
      mValid[i] = 0; mTag[i] = 0; mTarget[i] = 0; mCtr[i] = 1;
    end
  endtask

  task automatic modelEdge(input bit rst, input bit fl);
    int unsigned s;
    s = slotOf(upd_pc);
    if (rst) modelClear();
    else if (fl) begin
      for (int i = 0; i < N; i++) mValid[i] = 0;
    end else if (upd_valid) begin
      if (mValid[s] && mTag[s] == (upd_pc >> 6)) begin
        if (upd_taken) begin
          mTarget[s] = upd_target;
          mCtr[s] = (mCtr[s] + 1 > 3) ? 3 : mCtr[s] + 1;
        end else begin
          mCtr[s] = (mCtr[s] - 1 < 0) ? 0 : mCtr[s] - 1;
        end
      end else if (upd_taken) begin
        mValid[s] = 1; mTag[s] = upd_pc >> 6; mTarget[s] = upd_target; mCtr[s] = 2;
      end
    end
  endtask

  task automatic modelCheck();
    int unsigned s;
    bit hit;
    s = slotOf(lookup_pc);
    hit = mValid[s] && (mTag[s] == (lookup_pc >> 6));
    check("rand_hit", {31'd0, lookup_hit}, {31'd0, hit});
    check("rand_taken", {31'd0, predict_taken}, {31'd0, hit && (mCtr[s] >= 2)});
    check("rand_predpc", predicted_pc, hit ? mTarget[s] : lookup_pc + 32'd4);
    check("rand_occ", {27'd0, occupancy}, modelOcc());
  endtask

  function automatic logic [31:0] randPc();
    return 32'h0040_0000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 15) << 2)
           + $urandom_range(0, 3);
  endfunction

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    modelClear();
  endtask

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic [31:0] lpc;
    logic        eHit;
    logic        eTaken;
    logic [31:0] ePc;
    int unsigned eOcc;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Directed vectors: update applied at an edge, lookup checked after it.
    vecs.push_back('{1'b0, 32'h0, 1'b0, 32'h0, 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014, 0});
    vecs.push_back('{1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 1});
    vecs.push_back('{1'b1, 32'h0040_0010, 1'b0, 32'h0, 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100, 1});
    vecs.push_back('{1'b1, 32'h0040_0010, 1'b0, 32'h0, 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100, 1});
    vecs.push_back('{1'b1, 32'h0040_0010, 1'b0, 32'h0, 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100, 1});
    // Saturated at 00, so one taken update reaches 01 (not taken).
    vecs.push_back('{1'b1, 32'h0040_0012, 1'b1, 32'h0040_0200, 32'h0040_0011, 1'b1, 1'b0, 32'h0040_0200, 1});
    vecs.push_back('{1'b1, 32'h0040_0050, 1'b1, 32'h0040_0300, 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014, 1});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 32'h0, 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0300, 1});
    vecs.push_back('{1'b1, 32'h0040_0020, 1'b0, 32'h0040_0900, 32'h0040_0020, 1'b0, 1'b0, 32'h0040_0024, 1});
    vecs.push_back('{1'b0, 32'h0040_0024, 1'b1, 32'h0040_0900, 32'h0040_0024, 1'b0, 1'b0, 32'h0040_0028, 1});

    // Reset with a simultaneous update: the update must be dropped.
    upd_valid = 1'b1; upd_pc = 32'h0040_0010; upd_taken = 1'b1; upd_target = 32'h0040_0700;
    doReset();
    upd_valid = 1'b0;
    #1;
    check("reset_hit", {31'd0, lookup_hit}, 32'd0);
    check("reset_occ", {27'd0, occupancy}, 32'd0);

    foreach (vecs[k]) begin
      upd_valid = vecs[k].uv; upd_pc = vecs[k].upc; upd_taken = vecs[k].ut;
      upd_target = vecs[k].utgt; lookup_pc = vecs[k].lpc;
      @(posedge clk); #1;
      upd_valid = 1'b0;
      #1;
      check($sformatf("vec%0d_hit", k), {31'd0, lookup_hit}, {31'd0, vecs[k].eHit});
      check($sformatf("vec%0d_taken", k), {31'd0, predict_taken}, {31'd0, vecs[k].eTaken});
      check($sformatf("vec%0d_predpc", k), predicted_pc, vecs[k].ePc);
      check($sformatf("vec%0d_occ", k), {27'd0, occupancy}, vecs[k].eOcc);
    end

    // Same-cycle update and lookup on an invalid slot: no bypass.
    upd_valid = 1'b1; upd_pc = 32'h0040_0020; upd_taken = 1'b1; upd_target = 32'h0040_0400;
    lookup_pc = 32'h0040_0020;
    #1;
    check("nobypass_hit", {31'd0, lookup_hit}, 32'd0);
    check("nobypass_predpc", predicted_pc, 32'h0040_0024);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    #1;
    check("after_hit", {31'd0, lookup_hit}, 32'd1);
    check("after_taken", {31'd0, predict_taken}, 32'd1);
    check("after_predpc", predicted_pc, 32'h0040_0400);
    check("after_occ", {27'd0, occupancy}, 32'd2);

    // Fill all slots, then one aliased allocation.
    doReset();
    for (int i = 0; i < 16; i++) begin
      upd_valid = 1'b1; upd_pc = 32'h0050_0000 + i * 4; upd_taken = 1'b1;
      upd_target = 32'h0070_0000 + i * 4;
      @(posedge clk); #1;
      check($sformatf("fill%0d_occ", i), {27'd0, occupancy}, i + 1);
    end
    upd_pc = 32'h0060_0000; upd_target = 32'h0080_0000;
    @(posedge clk); #1;
    upd_valid = 1'b0;
    lookup_pc = 32'h0060_0000; #1;
    check("full_occ", {27'd0, occupancy}, 32'd16);
    check("alias_hit", {31'd0, lookup_hit}, 32'd1);
    check("alias_predpc", predicted_pc, 32'h0080_0000);
    lookup_pc = 32'h0050_0000; #1;
    check("evicted_hit", {31'd0, lookup_hit}, 32'd0);
    lookup_pc = 32'h0050_0004; #1;
    check("kept_predpc", predicted_pc, 32'h0070_0004);

    // Mid-operation reset discards everything in one edge.
    reset = 1'b1; upd_valid = 1'b1; upd_pc = 32'h0050_0008; upd_taken = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; upd_valid = 1'b0;
    #1;
    check("midreset_occ", {27'd0, occupancy}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      lookup_pc = 32'h0050_0000 + i * 4; #1;
      check($sformatf("midreset%0d_hit", i), {31'd0, lookup_hit}, 32'd0);
      check($sformatf("midreset%0d_predpc", i), predicted_pc, lookup_pc + 32'd4);
    end

`ifdef BTP_FLUSH_EN
    for (int i = 0; i < 3; i++) begin
      upd_valid = 1'b1; upd_pc = 32'h0050_0000 + i * 4; upd_taken = 1'b1;
      upd_target = 32'h0070_0000;
      @(posedge clk); #1;
    end
    check("preflush_occ", {27'd0, occupancy}, 32'd3);
    flush = 1'b1; upd_pc = 32'h0050_0010;
    @(posedge clk); #1;
    flush = 1'b0; upd_valid = 1'b0;
    #1;
    check("flush_occ", {27'd0, occupancy}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      lookup_pc = 32'h0050_0000 + i * 4; #1;
      check($sformatf("flush%0d_hit", i), {31'd0, lookup_hit}, 32'd0);
    end
`endif

    // Randomized phase against the behavioural model.
    doReset();
    for (int c = 0; c < 800; c++) begin
      bit rst;
      bit fl;
      rst = ($urandom_range(0, 99) == 0);
      fl = 0;
`ifdef BTP_FLUSH_EN
      fl = ($urandom_range(0, 59) == 0);
      flush = fl;
`endif
      reset = rst;
      upd_valid = ($urandom_range(0, 3) != 0);
      upd_pc = randPc();
      upd_taken = $urandom_range(0, 1);
      upd_target = $urandom;
      lookup_pc = ($urandom_range(0, 2) == 0) ? upd_pc : randPc();
      #2;
      modelCheck();
      @(posedge clk);
      modelEdge(rst, fl);
      #1;
    end
    reset = 1'b0; upd_valid = 1'b0;
`ifdef BTP_FLUSH_EN
    flush = 1'b0;
`endif
    #2;
    modelCheck();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, the number of direct-mapped entries (a power of 2, at least 2).
REQ-002 SHALL have parameter CTR_RESET, default 2'b01, the counter value loaded at reset (weakly not-taken).
REQ-003 SHALL have the port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have the port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have the port `lookup_pc`, input, 32 bits: fetch-stage PC.
REQ-006 SHALL have the port `lookup_hit`, output, 1 bit: a valid entry's tag matches `lookup_pc`.
REQ-007 SHALL have the port `predict_taken`, output, 1 bit: `lookup_hit` & counter[1].
REQ-008 SHALL have the port `predicted_pc`, output, 32 bits: the stored target when `lookup_hit`, else `lookup_pc`+4.
REQ-009 SHALL have the port `upd_valid`, input, 1 bit: a resolved branch is presented this cycle.
REQ-010 SHALL have the port `upd_pc`, input, 32 bits: the resolved branch address.
REQ-011 SHALL have the port `upd_taken`, input, 1 bit: the resolved direction.
REQ-012 SHALL have the port `upd_target`, input, 32 bits: the resolved target address.
REQ-013 SHALL have the port `occupancy`, output, clog2(ENTRIES)+1 bits: the count of valid entries.

Function
REQ-014 Indexing SHALL be: index = pc[IDX+1:2] and tag = pc[31:IDX+2], where IDX = clog2(ENTRIES); pc[1:0] are ignored.
REQ-015 Each entry SHALL hold {valid, tag, target[31:0], ctr[1:0]}.
REQ-016 Lookup SHALL be combinational from `lookup_pc` and the current registered state, with zero cycles of latency.
REQ-017 Lookup SHALL provide no bypass: when an update and a lookup hit the same index in the same cycle, the lookup SHALL reflect the pre-edge contents.
REQ-018 An update hit (`upd_valid`, entry valid, tag equal) SHALL increment ctr when `upd_taken` (saturating at 2'b11) and decrement it otherwise (saturating at 2'b00).
REQ-019 An update hit with `upd_taken` SHALL also overwrite target with `upd_target`.
REQ-020 An update miss with `upd_taken` SHALL allocate the entry: valid=1, tag=upd tag, target=`upd_target`, ctr=2'b10.
REQ-021 An update miss without `upd_taken` SHALL leave all state unchanged.
REQ-022 An allocation into an invalid entry SHALL increment `occupancy`.
REQ-023 An allocation replacing a valid, aliased entry SHALL leave `occupancy` unchanged.
REQ-024 `occupancy` SHALL never exceed ENTRIES, and SHALL stay at ENTRIES while all entries are valid.
REQ-025 With `upd_valid`=0, all entry state and `occupancy` SHALL hold.
REQ-026 At most one entry SHALL change per cycle.

Reset
REQ-027 While `reset` is high at a rising edge, all valid bits SHALL clear, every ctr SHALL load CTR_RESET, tags and targets SHALL load 0, and `occupancy` SHALL load 0.
REQ-028 Reset SHALL override any simultaneous update (and flush, when present).
REQ-029 After reset, `lookup_hit`=0, `predict_taken`=0 and `predicted_pc`=`lookup_pc`+4 for every `lookup_pc`.
REQ-030 Reset asserted mid-operation SHALL discard all learned entries within one edge.

Configuration
REQ-031 Macro BTP_FLUSH_EN SHALL, when defined, add the port `flush`, input, 1 bit.
REQ-032 With BTP_FLUSH_EN defined, `flush` high at an edge SHALL clear all valid bits and `occupancy` (ctr, tag and target untouched), taking priority over a simultaneous update, which is dropped.
REQ-033 With BTP_FLUSH_EN undefined, the `flush` port and its logic SHALL be absent, and entries SHALL clear only via `reset`.

Verification (ENTRIES=16)
REQ-034 Bench SHALL cover: reset, then lookup 0x00400010 -> hit=0, predict_taken=0, predicted_pc=0x00400014, occupancy=0.
REQ-035 Bench SHALL cover: update {pc 0x00400010, taken, target 0x00400100}, next cycle lookup 0x00400010 -> hit=1, predict_taken=1 (ctr=10), predicted_pc=0x00400100, occupancy=1.
REQ-036 Bench SHALL cover: two not-taken updates to 0x00400010 -> ctr 10 then 01, then 00; lookup hit=1, predict_taken=0; a third not-taken update keeps ctr=00.
REQ-037 Bench SHALL cover: taken update to 0x00400050 (same index 4, different tag) -> replaces the entry, occupancy stays 1, lookup 0x00400010 gives hit=0.
REQ-038 Bench SHALL cover: update and lookup both at 0x00400020 in the same cycle with the entry invalid -> that cycle hit=0, next cycle hit=1.
REQ-039 Bench SHALL cover: 16 taken updates to distinct indices -> occupancy=16, a 17th allocation keeps 16; with BTP_FLUSH_EN, flush+update in the same cycle -> occupancy=0, all lookups miss.
